fas_rd_req_arbiter: RTL and testbench

- Memory-side read responder for the FAS initiator read channel.
- Accepts per-lane read requests from FAS (one lane per read ID), arbitrates round-robin, and issues one burst command to the memory read port.
- Steers the returning beats back to the granted lane with vld/rdy flow control, then signals completion.
- One transaction in flight at a time.

---
 rtl/fas_rd_pkg.sv | 37 +++
 rtl/fas_rr_arb.sv | 37 +++
 rtl/fas_rd_req_arbiter.sv | 133 +++++++++++++
 tb/tb_fas_rd_req_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fas_rd_pkg.sv
// ----------------------------------------------------------------------------
// fas_rd_pkg : shared types, default widths and lane-slice helper for FAS read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fas_rd_pkg;

  localparam int C_DEF_NUM_RD_ID = 4;
  localparam int C_DEF_ADDR_WTH  = 32;
  localparam int C_DEF_LEN_WTH   = 16;
  localparam int C_DEF_DATA_WTH  = 512;

  // Upper bounds the slice helper can handle for packed per-lane buses.
  localparam int C_MAX_BUS_WTH   = 4096;
  localparam int C_MAX_FIELD_WTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_CMPL = 2'd3
  } state_t;

  function automatic logic [C_MAX_FIELD_WTH-1:0] lane_slice(
    input logic [C_MAX_BUS_WTH-1:0] bus,
    input int                       lane,
    input int                       wth
  );
    logic [C_MAX_BUS_WTH-1:0] sh;
    sh = bus >> (lane * wth);
    return sh[C_MAX_FIELD_WTH-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fas_rr_arb.sv
// ----------------------------------------------------------------------------
// fas_rr_arb : combinational rotate-priority arbiter, first request at/after ptr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fas_rr_arb #(
  parameter int C_NUM     = 4,
  parameter int C_IDX_WTH = 2
) (
  input  logic [C_NUM-1:0]     req,
  input  logic [C_IDX_WTH-1:0] ptr,
  output logic [C_NUM-1:0]     gnt,
  output logic [C_IDX_WTH-1:0] gnt_idx,
  output logic                 any_req
);

  int w_lane;

  // Scan farthest-to-nearest so the lane closest to ptr overrides the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_lane  = 0;
    any_req = |req;
    for (int k = C_NUM - 1; k >= 0; k--) begin
      w_lane = (int'(ptr) + k) % C_NUM;
      if (req[w_lane]) begin
        gnt     = C_NUM'(1) << w_lane;
        gnt_idx = C_IDX_WTH'(w_lane);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fas_rd_req_arbiter.sv
// ----------------------------------------------------------------------------
// fas_rd_req_arbiter : round-robin FAS read lanes onto one memory read port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fas_rd_req_arbiter
  import fas_rd_pkg::*;
#(
  parameter int C_NUM_RD_ID = C_DEF_NUM_RD_ID,
  parameter int C_ADDR_WTH  = C_DEF_ADDR_WTH,
  parameter int C_LEN_WTH   = C_DEF_LEN_WTH,
  parameter int C_DATA_WTH  = C_DEF_DATA_WTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_NUM_RD_ID-1:0]            init_read_req,
  input  logic [C_NUM_RD_ID*C_ADDR_WTH-1:0] init_read_addr,
  input  logic [C_NUM_RD_ID*C_LEN_WTH-1:0]  init_read_len,
  output logic [C_NUM_RD_ID-1:0]            init_read_req_ack,
  output logic [C_NUM_RD_ID-1:0]            init_read_in_prog,
  output logic [C_DATA_WTH-1:0]             init_read_data,
  output logic [C_NUM_RD_ID-1:0]            init_read_data_vld,
  input  logic [C_NUM_RD_ID-1:0]            init_read_data_rdy,
  output logic [C_NUM_RD_ID-1:0]            init_read_cmpl,
  output logic                              mem_rd_cmd_vld,
  input  logic                              mem_rd_cmd_rdy,
  output logic [C_ADDR_WTH-1:0]             mem_rd_cmd_addr,
  output logic [C_LEN_WTH-1:0]              mem_rd_cmd_len,
  input  logic [C_DATA_WTH-1:0]             mem_rd_data,
  input  logic                              mem_rd_data_vld,
  output logic                              mem_rd_data_rdy
);

  localparam int C_IDX_WTH = (C_NUM_RD_ID > 1) ? $clog2(C_NUM_RD_ID) : 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [C_IDX_WTH-1:0]   r_ptr;
  logic [C_IDX_WTH-1:0]   r_gnt_idx;
  logic [C_NUM_RD_ID-1:0] r_gnt_oh;
  logic [C_ADDR_WTH-1:0]  r_addr;
  logic [C_LEN_WTH-1:0]   r_len;
  logic [C_LEN_WTH-1:0]   r_cnt;
  logic                   r_ack;

  logic [C_NUM_RD_ID-1:0] w_arb_gnt;
  logic [C_IDX_WTH-1:0]   w_arb_idx;
  logic                   w_any_req;
  logic [C_ADDR_WTH-1:0]  w_sel_addr;
  logic [C_LEN_WTH-1:0]   w_sel_len;
  logic                   w_data_rdy;
  logic                   w_beat;

  fas_rr_arb #(
    .C_NUM     (C_NUM_RD_ID),
    .C_IDX_WTH (C_IDX_WTH)
  ) u_arb (
    .req     (init_read_req),
    .ptr     (r_ptr),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx),
    .any_req (w_any_req)
  );

  assign w_sel_addr = C_ADDR_WTH'(lane_slice(C_MAX_BUS_WTH'(init_read_addr), int'(w_arb_idx), C_ADDR_WTH));
  assign w_sel_len  = C_LEN_WTH'(lane_slice(C_MAX_BUS_WTH'(init_read_len), int'(w_arb_idx), C_LEN_WTH));
  assign w_data_rdy = (r_state == ST_DATA) && init_read_data_rdy[r_gnt_idx];
  assign w_beat     = w_data_rdy && mem_rd_data_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_nxt = (w_sel_len == '0) ? ST_CMPL : ST_CMD;
      ST_CMD:  if (mem_rd_cmd_rdy) w_state_nxt = ST_DATA;
      ST_DATA: if (w_beat && (r_cnt == C_LEN_WTH'(1))) w_state_nxt = ST_CMPL;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_gnt_oh  <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_ack     <= 1'b1;
            r_gnt_idx <= w_arb_idx;
            r_gnt_oh  <= w_arb_gnt;
            r_addr    <= w_sel_addr;
            r_len     <= w_sel_len;
            r_ptr     <= (w_arb_idx == C_IDX_WTH'(C_NUM_RD_ID - 1)) ? '0 : w_arb_idx + 1'b1;
          end
        end
        ST_CMD:  if (mem_rd_cmd_rdy) r_cnt <= r_len;
        ST_DATA: if (w_beat) r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Every output is decoded from registered state, so async reset clears them at once.
  always_comb begin
    init_read_req_ack  = r_ack ? r_gnt_oh : '0;
    init_read_in_prog  = (r_state != ST_IDLE) ? r_gnt_oh : '0;
    init_read_cmpl     = (r_state == ST_CMPL) ? r_gnt_oh : '0;
    mem_rd_cmd_vld     = (r_state == ST_CMD);
    mem_rd_cmd_addr    = (r_state == ST_CMD) ? r_addr : '0;
    mem_rd_cmd_len     = (r_state == ST_CMD) ? r_len : '0;
    init_read_data     = (r_state == ST_DATA) ? mem_rd_data : '0;
    init_read_data_vld = ((r_state == ST_DATA) && mem_rd_data_vld) ? r_gnt_oh : '0;
    mem_rd_data_rdy    = w_data_rdy;
  end

endmodule

`default_nettype wire

// File: tb/tb_fas_rd_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fas_rd_req_arbiter : scoreboard bench for the FAS read request arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fas_rd_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    init_read_req = '0;
  logic [N*AW-1:0] init_read_addr = '0;
  logic [N*LW-1:0] init_read_len = '0;
  logic [N-1:0]    init_read_req_ack;
  logic [N-1:0]    init_read_in_prog;
  logic [DW-1:0]   init_read_data;
  logic [N-1:0]    init_read_data_vld;
  logic [N-1:0]    init_read_data_rdy = '0;
  logic [N-1:0]    init_read_cmpl;
  logic            mem_rd_cmd_vld;
  logic            mem_rd_cmd_rdy = 1'b0;
  logic [AW-1:0]   mem_rd_cmd_addr;
  logic [LW-1:0]   mem_rd_cmd_len;
  logic [DW-1:0]   mem_rd_data = '0;
  logic            mem_rd_data_vld = 1'b0;
  logic            mem_rd_data_rdy;

  typedef struct packed {
    logic [1:0]    lane;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    txn   = 0;
  int    dummy;

  fas_rd_req_arbiter #(
    .C_NUM_RD_ID (N),
    .C_ADDR_WTH  (AW),
    .C_LEN_WTH   (LW),
    .C_DATA_WTH  (DW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .init_read_req      (init_read_req),
    .init_read_addr     (init_read_addr),
    .init_read_len      (init_read_len),
    .init_read_req_ack  (init_read_req_ack),
    .init_read_in_prog  (init_read_in_prog),
    .init_read_data     (init_read_data),
    .init_read_data_vld (init_read_data_vld),
    .init_read_data_rdy (init_read_data_rdy),
    .init_read_cmpl     (init_read_cmpl),
    .mem_rd_cmd_vld     (mem_rd_cmd_vld),
    .mem_rd_cmd_rdy     (mem_rd_cmd_rdy),
    .mem_rd_cmd_addr    (mem_rd_cmd_addr),
    .mem_rd_cmd_len     (mem_rd_cmd_len),
    .mem_rd_data        (mem_rd_data),
    .mem_rd_data_vld    (mem_rd_data_vld),
    .mem_rd_data_rdy    (mem_rd_data_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int t, input int k);
    return {16{16'(t), 16'(k)}};
  endfunction

  function automatic logic [N-1:0] onehot(input int lane);
    logic [N-1:0] v;
    v = '0;
    v[lane] = 1'b1;
    return v;
  endfunction

  function automatic logic outs_zero();
    return ({init_read_req_ack, init_read_in_prog, init_read_data_vld, init_read_cmpl,
             mem_rd_cmd_vld, mem_rd_cmd_addr, mem_rd_cmd_len, mem_rd_data_rdy} == '0)
           && (init_read_data == '0);
  endfunction

  task automatic set_lane(input int lane, input logic [AW-1:0] a, input int l);
    init_read_addr[lane*AW +: AW] = a;
    init_read_len[lane*LW +: LW]  = LW'(l);
  endtask

  // Scoreboard consumer: every FAS-side handshake pops the next expected beat.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        if (init_read_data_vld[i] && init_read_data_rdy[i]) begin
          beat_t e;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected: lane %0d data %h, no beat expected", i, init_read_data[31:0]);
          end else begin
            e = exp_q.pop_front();
            if (e.lane !== 2'(i) || init_read_data !== e.data) begin
              bad++;
              $display("FAIL beat_data: got lane %0d data %h, expected lane %0d data %h",
                       i, init_read_data[31:0], e.lane, e.data[31:0]);
            end
          end
        end
      end
    end
  end

  // One full transaction from the requester's and the memory's point of view.
  task automatic serve(input int lane, input logic [AW-1:0] ex_addr, input int ex_len,
                       input int cmd_stall, input bit bp, output int ack_wait);
    int n;
    int acc;
    int c;
    logic [N-1:0] oh;
    oh = onehot(lane);
    txn++;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (init_read_req_ack === '0 && n < 40);
    ack_wait = n;
    total++;
    if (init_read_req_ack !== oh) begin
      bad++;
      $display("FAIL ack_lane: got %b expected %b", init_read_req_ack, oh);
      init_read_req[lane] = 1'b0;
      return;
    end
    total++;
    if (init_read_in_prog !== oh) begin
      bad++;
      $display("FAIL in_prog_rise: got %b expected %b", init_read_in_prog, oh);
    end
    init_read_req[lane] = 1'b0;

    if (ex_len == 0) begin
      total++;
      if (init_read_cmpl !== oh || mem_rd_cmd_vld !== 1'b0) begin
        bad++;
        $display("FAIL zero_len_cmpl: cmpl=%b cmd_vld=%b expected cmpl=%b cmd_vld=0", init_read_cmpl, mem_rd_cmd_vld, oh);
      end
      @(negedge clk); #1;
      total++;
      if (init_read_in_prog !== '0 || init_read_cmpl !== '0 || mem_rd_cmd_vld !== 1'b0) begin
        bad++;
        $display("FAIL zero_len_after: in_prog=%b cmpl=%b cmd_vld=%b expected all 0", init_read_in_prog, init_read_cmpl, mem_rd_cmd_vld);
      end
      return;
    end

    // Memory offers data early; it must be held off until the command is taken.
    init_read_data_rdy = '1;
    mem_rd_data_vld    = 1'b1;
    mem_rd_data        = pat(txn, 0);
    for (int s = 0; s <= cmd_stall; s++) begin
      if (s > 0) begin
        @(negedge clk); #1;
      end
      total++;
      if (mem_rd_cmd_vld !== 1'b1 || mem_rd_cmd_addr !== ex_addr || mem_rd_cmd_len !== LW'(ex_len)
          || mem_rd_data_rdy !== 1'b0 || init_read_data_vld !== '0) begin
        bad++;
        $display("FAIL cmd_phase: vld=%b addr=%h len=%0d drdy=%b dvld=%b expected vld=1 addr=%h len=%0d drdy=0 dvld=0",
                 mem_rd_cmd_vld, mem_rd_cmd_addr, mem_rd_cmd_len, mem_rd_data_rdy, init_read_data_vld, ex_addr, ex_len);
      end
    end
    mem_rd_cmd_rdy = 1'b1;
    for (int k = 0; k < ex_len; k++) exp_q.push_back('{lane: 2'(lane), data: pat(txn, k)});

    acc = 0;
    c   = 0;
    while (acc < ex_len && c < 200) begin
      @(negedge clk);
      mem_rd_cmd_rdy           = 1'b0;
      init_read_data_rdy[lane] = bp ? (c % 2 == 0) : 1'b1;
      mem_rd_data_vld          = !(bp && (c == 5 || c == 6));
      mem_rd_data              = pat(txn, acc);
      #1;
      total++;
      if (mem_rd_data_rdy !== init_read_data_rdy[lane] || init_read_data_vld !== (mem_rd_data_vld ? oh : '0)) begin
        bad++;
        $display("FAIL data_flow: mem_rdy=%b vld=%b expected mem_rdy=%b vld=%b", mem_rd_data_rdy, init_read_data_vld,
                 init_read_data_rdy[lane], (mem_rd_data_vld ? oh : '0));
      end
      if (mem_rd_data_vld && init_read_data_rdy[lane]) acc++;
      c++;
    end
    if (acc < ex_len) begin
      total++;
      bad++;
      $display("FAIL data_timeout: got %0d beats expected %0d", acc, ex_len);
    end

    @(negedge clk);
    mem_rd_data_vld    = 1'b0;
    init_read_data_rdy = '0;
    #1;
    total++;
    if (init_read_cmpl !== oh || init_read_in_prog !== oh) begin
      bad++;
      $display("FAIL cmpl_pulse: cmpl=%b in_prog=%b expected %b", init_read_cmpl, init_read_in_prog, oh);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL beats_left: got %0d outstanding expected 0", exp_q.size());
    end
    @(negedge clk); #1;
    total++;
    if (init_read_cmpl !== '0 || init_read_in_prog !== '0 || mem_rd_data_rdy !== 1'b0) begin
      bad++;
      $display("FAIL cmpl_after: cmpl=%b in_prog=%b drdy=%b expected all 0", init_read_cmpl, init_read_in_prog, mem_rd_data_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (!outs_zero()) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b in_prog=%b cmd_vld=%b expected all 0", init_read_req_ack, init_read_in_prog, mem_rd_cmd_vld);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if (!outs_zero()) begin
      bad++;
      $display("FAIL idle_outputs: got ack=%b in_prog=%b cmd_vld=%b expected all 0", init_read_req_ack, init_read_in_prog, mem_rd_cmd_vld);
    end
  endtask

  task automatic test_round_robin();
    set_lane(0, 32'h0000_0100, 2);
    set_lane(1, 32'h0000_0200, 2);
    set_lane(3, 32'h0000_0300, 2);
    @(negedge clk);
    init_read_req = 4'b1011;
    serve(0, 32'h0000_0100, 2, 0, 1'b0, dummy);
    set_lane(0, 32'h0000_0400, 1);
    init_read_req[0] = 1'b1;
    serve(1, 32'h0000_0200, 2, 0, 1'b0, dummy);
    serve(3, 32'h0000_0300, 2, 0, 1'b0, dummy);
    serve(0, 32'h0000_0400, 1, 0, 1'b0, dummy);
  endtask

  task automatic test_single();
    int aw;
    set_lane(2, 32'h0000_1000, 4);
    @(negedge clk);
    init_read_req[2] = 1'b1;
    serve(2, 32'h0000_1000, 4, 0, 1'b0, aw);
    total++;
    if (aw !== 1) begin
      bad++;
      $display("FAIL ack_latency: got %0d cycles expected 1", aw);
    end
  endtask

  task automatic test_backpressure();
    set_lane(3, 32'hA5A5_0040, 8);
    @(negedge clk);
    init_read_req[3] = 1'b1;
    serve(3, 32'hA5A5_0040, 8, 0, 1'b1, dummy);
  endtask

  task automatic test_zero_len();
    set_lane(1, 32'h0000_7000, 0);
    @(negedge clk);
    init_read_req[1] = 1'b1;
    serve(1, 32'h0000_7000, 0, 0, 1'b0, dummy);
  endtask

  task automatic test_cmd_stall();
    set_lane(0, 32'hDEAD_BEE0, 3);
    @(negedge clk);
    init_read_req[0] = 1'b1;
    serve(0, 32'hDEAD_BEE0, 3, 5, 1'b0, dummy);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    int acc;
    txn++;
    set_lane(2, 32'h0000_2000, 6);
    @(negedge clk);
    init_read_req[2] = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (init_read_req_ack === '0 && n < 40);
    total++;
    if (init_read_req_ack !== 4'b0100) begin
      bad++;
      $display("FAIL rst_ack: got %b expected 0100", init_read_req_ack);
    end
    init_read_req[2]   = 1'b0;
    init_read_data_rdy = '1;
    mem_rd_data_vld    = 1'b1;
    mem_rd_cmd_rdy     = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back('{lane: 2'd2, data: pat(txn, k)});
    acc = 0;
    n   = 0;
    while (acc < 3 && n < 40) begin
      @(negedge clk);
      mem_rd_cmd_rdy = 1'b0;
      mem_rd_data    = pat(txn, acc);
      #1;
      if (mem_rd_data_vld && mem_rd_data_rdy) acc++;
      n++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (!outs_zero()) begin
      bad++;
      $display("FAIL rst_outputs: got in_prog=%b dvld=%b drdy=%b expected all 0", init_read_in_prog, init_read_data_vld, mem_rd_data_rdy);
    end
    total++;
    if (exp_q.size() != 3) begin
      bad++;
      $display("FAIL rst_beats: got %0d undelivered expected 3", exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    // Lanes 0 and 3 together: only a cleared pointer makes lane 0 win.
    set_lane(0, 32'h0000_3000, 2);
    set_lane(3, 32'h0000_5000, 1);
    rst           = 1'b1;
    init_read_req = 4'b1001;
    serve(0, 32'h0000_3000, 2, 0, 1'b0, dummy);
    serve(3, 32'h0000_5000, 1, 0, 1'b0, dummy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_zero_len();
    test_cmd_stall();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
